riscv_ifu: RTL and testbench
============================

Name: riscv_ifu

Overview:
- Instruction fetch stage directly upstream of the control decoder.
- Holds the PC and issues in-order word fetches to instruction memory over a valid/ready request channel plus an always-accepted response channel.
- Buffers returned instructions in a small FIFO and presents {pc, inst, opcode} to decode with a valid/ready handshake.
- Discards wrong-path instructions on a redirect from the branch/jump resolution logic.

Parameters:
XLEN, 64, PC and address width (RV64; OP_32/OP_IMM_32 are decoded downstream).
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
FIFO_DEPTH, 2, instruction buffer entries; also the maximum in-flight plus buffered fetch count (power of two, ≥2).

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address, bits[1:0] always 0
imem_resp_valid  in  1  one response per accepted request, in order, never back-pressured
imem_resp_data  in  32  fetched instruction word
redirect_valid  in  1  control-flow redirect (taken branch, JAL/JALR)
redirect_pc  in  XLEN  redirect target
if_valid  out  1  instruction available to decode
if_ready  in  1  decode consumes the instruction
if_pc  out  XLEN  PC of the presented instruction
if_inst  out  32  presented instruction
if_opcode  out  7  if_inst[6:0], feeds decoder opcode input

Behaviour:
- Reset (rst high at an edge):
  - pc=RESET_PC; FIFO empty; outstanding=0; stale=0.
  - Outputs: if_valid=0; imem_req_valid=0 while rst is high; imem_req_addr=RESET_PC.
  - Reset mid-operation drops all buffered and in-flight fetches. Memory must not return responses for pre-reset requests.
- Credit rule:
  - imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH).
  - A same-cycle pop does not free a credit until the next cycle.
- Request handshake and PC advance:
  - A request is accepted when imem_req_valid && imem_req_ready.
  - On accept: pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
  - Once asserted, imem_req_addr is held stable until accepted. A redirect is the only event that may withdraw a pending request.
- Responses:
  - Each response decrements outstanding.
  - When stale>0, the response is dropped and stale decrements.
  - Otherwise {pc_of_request, data} is pushed to the FIFO. The request PC is tracked in a FIFO_DEPTH-entry address queue or an equivalent mechanism.
  - Push visible at if_valid the next cycle: no combinational resp-to-if bypass. Minimum fetch latency is request accept → response (≥1 cycle) → if_valid one cycle later.
- Decode interface:
  - if_valid = FIFO non-empty; if_pc/if_inst/if_opcode driven from the FIFO head.
  - Pop on if_valid && if_ready.
  - Outputs are stable while if_valid && !if_ready.
  - Simultaneous push and pop is allowed at any occupancy, including full.
- Redirect (highest priority):
  - In the redirect cycle: FIFO flushed (if_valid=0 next cycle); no request issued; any response arriving is dropped.
  - stale <= outstanding minus the response dropped that cycle, if any.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - An if_ready handshake in the redirect cycle still counts as consumed.
  - Back-to-back redirects: each recomputes stale from the current outstanding; the last target wins.
- Invariants:
  - outstanding + fifo_count ≤ FIFO_DEPTH at all times.
  - A response with outstanding==0 is a protocol error: assertion only, no recovery.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr-derived words, if_ready=1 → first request addr 0x8000_0000; requests 0x8000_0000, 0x8000_0004, 0x8000_0008… in order; if_pc/if_inst match; if_opcode=inst[6:0].
- Hold if_ready=0 → exactly 2 requests accepted, then imem_req_valid=0; if_valid held with stable head; release if_ready → fetching resumes with no loss or duplication.
- imem_req_ready=0 for 5 cycles → imem_req_valid stays high with addr 0x8000_0000 stable; accepted on the first ready cycle.
- Memory latency 3 cycles, 2 requests in flight, redirect_valid with redirect_pc=0x8000_0102 → both stale responses dropped; next request addr 0x8000_0100; first if_pc after the redirect is 0x8000_0100.
- Redirect in the same cycle as a response and an if_ready pop → response dropped, popped entry consumed, FIFO empty next cycle, stale count correct.
- pc=0xFFFF_FFFF_FFFF_FFFC, accept → next addr 0x0; assert rst mid-stream → if_valid=0 and imem_req_valid=0 during reset, first post-reset request at RESET_PC.

Source files
------------

// File: rtl/riscv_ifu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ifu
// Brief    : RV64 instruction fetch unit with credit-limited in-order fetch,
//            instruction buffer and redirect flush toward the decoder.
// Revision : 1.0
// ============================================================================
module riscv_ifu #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    output logic [6:0]      if_opcode
);
    localparam int                 c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w:0]   c_depth = FIFO_DEPTH[c_cnt_w:0];

    logic [XLEN-1:0]    r_pc;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_stale;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_aq_rd;
    logic [c_ptr_w-1:0] r_aq_wr;
    logic [XLEN-1:0]    r_aq        [FIFO_DEPTH];
    logic [XLEN-1:0]    r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]        r_fifo_inst [FIFO_DEPTH];

    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w:0]   w_credit_sum;

    // Buffered plus in-flight fetches share one pool of FIFO_DEPTH credits.
    assign w_credit_sum   = {1'b0, r_outstanding} + {1'b0, r_count};
    assign imem_req_valid = !rst && !redirect_valid && (w_credit_sum < c_depth);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_push    = imem_resp_valid && !redirect_valid && (r_stale == '0);
    assign if_valid  = (r_count != '0);
    assign w_pop     = if_valid && if_ready;
    assign if_pc     = r_fifo_pc[r_rd_ptr];
    assign if_inst   = r_fifo_inst[r_rd_ptr];
    assign if_opcode = if_inst[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_aq_rd       <= '0;
            r_aq_wr       <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(imem_resp_valid);
            // The address queue tracks every response, stale or not, to stay aligned.
            if (w_req_fire)
                r_aq_wr <= r_aq_wr + c_ptr_w'(1);
            if (imem_resp_valid)
                r_aq_rd <= r_aq_rd + c_ptr_w'(1);

            if (redirect_valid) begin
                r_pc     <= redirect_pc & ~XLEN'(3);
                r_stale  <= r_outstanding - c_cnt_w'(imem_resp_valid);
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_req_fire)
                    r_pc <= r_pc + XLEN'(4);
                if (imem_resp_valid && (r_stale != '0))
                    r_stale <= r_stale - c_cnt_w'(1);
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire)
            r_aq[r_aq_wr] <= r_pc;
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_aq[r_aq_rd];
            r_fifo_inst[r_wr_ptr] <= imem_resp_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && (r_outstanding == '0)));
            assert (w_credit_sum <= c_depth);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_ifu
// Brief    : Directed self-checking bench for riscv_ifu with a latency memory.
// Revision : 1.0
// ============================================================================
module tb_riscv_ifu;
    localparam logic [63:0] c_rst_pc = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic [6:0]  if_opcode;

    always #5 clk = ~clk;

    riscv_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_opcode       (if_opcode)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          n_cmp  = 0;
    int          n_err  = 0;
    int          cyc    = 0;
    int          lat    = 1;
    int          n_fire = 0;
    int          n_pop  = 0;
    logic [63:0] exp_req;
    logic [63:0] exp_out;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive memory response, score handshakes, advance to next negedge.
    task automatic tick();
        mreq_t       m;
        logic [31:0] w;
        if (rst) begin
            mq.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(m.addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        if (if_valid && if_ready) begin
            n_pop++;
            w = mem_word(exp_out);
            check("sb_pc", if_pc, exp_out);
            check("sb_inst", if_inst, w);
            check("sb_opcode", if_opcode, w[6:0]);
            exp_out = exp_out + 64'd4;
        end
        if (redirect_valid)
            check("redir_no_req", imem_req_valid, 1'b0);
        if (imem_req_valid && imem_req_ready) begin
            n_fire++;
            check("sb_req_addr", imem_req_addr, exp_req);
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
            exp_req = exp_req + 64'd4;
        end
        if (rst) begin
            exp_req = c_rst_pc;
            exp_out = c_rst_pc;
        end else if (redirect_valid) begin
            exp_req = {redirect_pc[63:2], 2'b00};
            exp_out = {redirect_pc[63:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_if_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (if_valid) break;
            tick();
        end
        check(tag, if_valid, 1'b1);
    endtask

    initial begin
        int  f0;
        int  p0;
        logic found;

        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
        exp_req = c_rst_pc; exp_out = c_rst_pc;
        @(negedge clk);
        tick();
        tick();
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_addr", imem_req_addr, c_rst_pc);

        // Memory not ready: request held with stable address.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_req_valid", imem_req_valid, 1'b1);
            check("stall_addr", imem_req_addr, c_rst_pc);
            tick();
        end
        check("stall_no_fire", n_fire, 0);

        // Streaming with 1-cycle memory.
        imem_req_ready = 1'b1;
        lat = 1;
        tick();
        check("first_fire", n_fire, 1);
        check("addr_after_fire", imem_req_addr, c_rst_pc + 64'd4);
        check("c1_if_valid", if_valid, 1'b0);
        tick();
        check("c2_fires", n_fire, 2);
        check("c2_if_valid", if_valid, 1'b1);
        check("c2_if_pc", if_pc, c_rst_pc);
        check("c2_if_inst", if_inst, mem_word(c_rst_pc));
        repeat (12) tick();
        check("stream_progress", (n_pop >= 6), 1'b1);

        // Decode back-pressure after a flush: exactly two fetches fill the buffer.
        if_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_8000_0200;
        tick();
        redirect_valid = 1'b0;
        f0 = n_fire;
        repeat (10) tick();
        check("bp_fires", n_fire - f0, 2);
        #1;
        check("bp_req_valid", imem_req_valid, 1'b0);
        check("bp_if_valid", if_valid, 1'b1);
        check("bp_head_pc", if_pc, 64'h0000_0000_8000_0200);
        tick();
        tick();
        check("bp_head_stable", if_pc, 64'h0000_0000_8000_0200);
        check("bp_inst_stable", if_inst, mem_word(64'h0000_0000_8000_0200));
        if_ready = 1'b1;
        p0 = n_pop;
        repeat (10) tick();
        check("bp_resume", (n_pop - p0 >= 4), 1'b1);

        // 3-cycle memory, redirect with two fetches in flight.
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mq.size() == 2 && !if_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t4_setup", found, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_8000_0102;
        tick();
        redirect_valid = 1'b0;
        check("t4_addr", imem_req_addr, 64'h0000_0000_8000_0100);
        wait_if_valid("t4_wait");
        check("t4_if_pc", if_pc, 64'h0000_0000_8000_0100);
        repeat (6) tick();

        // Redirect coinciding with a response and a pop.
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (if_valid && mq.size() > 0 && mq[0].due <= cyc) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t5_setup", found, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_8000_0400;
        tick();
        redirect_valid = 1'b0;
        check("t5_flushed", if_valid, 1'b0);
        wait_if_valid("t5_wait");
        check("t5_if_pc", if_pc, 64'h0000_0000_8000_0400);
        repeat (4) tick();

        // PC wrap then mid-stream reset.
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_pre_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 20; i++) begin
            f0 = n_fire;
            tick();
            if (n_fire != f0) break;
        end
        check("wrap_addr", imem_req_addr, 64'h0);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        #1;
        check("mid_rst_req_valid", imem_req_valid, 1'b0);
        check("mid_rst_if_valid", if_valid, 1'b0);
        tick();
        check("mid_rst_if_valid2", if_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_addr", imem_req_addr, c_rst_pc);
        check("post_rst_req_valid", imem_req_valid, 1'b1);
        wait_if_valid("post_rst_wait");
        check("post_rst_if_pc", if_pc, c_rst_pc);
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
